// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : RV32M multi-cycle multiply/divide (shift-add / restoring divide)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] C_LAST_STEP = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_op;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;       // multiply: {hi, multiplier}; divide: {rem, quo}
    logic [31:0] r_opnd;      // multiplicand or divisor magnitude
    logic        r_special;
    logic        r_neg;
    logic        r_neg_rem;
    logic [31:0] r_result;

    // Accept-time decode
    logic        w_accept;
    logic        w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div_zero, w_div_ovf, w_special;
    logic [31:0] w_special_res;

    assign w_accept   = req_valid && (r_state == S_IDLE) && !flush;
    assign w_a_signed = req_op[2] ? !req_op[0] : (req_op != 3'd3);
    assign w_b_signed = req_op[2] ? !req_op[0] : !req_op[1];
    assign w_sign_a   = w_a_signed && req_a[31];
    assign w_sign_b   = w_b_signed && req_b[31];
    assign w_mag_a    = w_sign_a ? -req_a : req_a;
    assign w_mag_b    = w_sign_b ? -req_b : req_b;
    assign w_div_zero = req_op[2] && (req_b == 32'd0);
    assign w_div_ovf  = req_op[2] && !req_op[0] && (req_a == 32'h8000_0000)
                        && (req_b == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = 32'd0;
        if (w_div_zero)
            w_special_res = req_op[1] ? req_a : 32'hFFFF_FFFF;
        else if (w_div_ovf)
            w_special_res = req_op[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration step of each algorithm
    logic [32:0] w_add;
    logic [63:0] w_mul_next;
    logic [32:0] w_trial;
    logic        w_no_borrow;
    logic [31:0] w_sub;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;
    logic [31:0] w_final;
    logic        w_last;

    assign w_add       = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next  = {w_add, r_acc[31:1]};
    assign w_trial     = r_acc[63:31];
    assign w_no_borrow = (w_trial >= {1'b0, r_opnd});
    // On no-borrow the true difference is below 2^32, so the low word is exact
    assign w_sub       = w_trial[31:0] - r_opnd;
    assign w_div_next  = {(w_no_borrow ? w_sub : w_trial[31:0]), r_acc[30:0], w_no_borrow};
    assign w_prod      = r_neg ? -w_mul_next : w_mul_next;
    assign w_quo       = r_neg ? -w_div_next[31:0] : w_div_next[31:0];
    assign w_rem       = r_neg_rem ? -w_div_next[63:32] : w_div_next[63:32];
    assign w_last      = r_special || (r_cnt == 5'd0);

    always_comb begin
        w_final = w_prod[63:32];
        case (r_op)
            3'd0:       w_final = w_prod[31:0];
            3'd4, 3'd5: w_final = w_quo;
            3'd6, 3'd7: w_final = w_rem;
            default:    w_final = w_prod[63:32];
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (req_valid)  w_next_state = S_BUSY;
                S_BUSY:  if (w_last)     w_next_state = S_DONE;
                S_DONE:  if (resp_ready) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_DONE);
        busy       = (r_state != S_IDLE);
    end

    assign resp_result = r_result;

    // Datapath; special cases park their result in r_acc for one BUSY cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op      <= 3'd0;
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            r_opnd    <= 32'd0;
            r_special <= 1'b0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= 32'd0;
        end else if (w_accept) begin
            r_op      <= req_op;
            r_cnt     <= C_LAST_STEP;
            r_acc     <= {32'd0, (w_special ? w_special_res : w_mag_a)};
            r_opnd    <= w_mag_b;
            r_special <= w_special;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
        end else if ((r_state == S_BUSY) && !flush) begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - 5'd1;
            if (w_last)
                r_result <= r_special ? r_acc[31:0] : w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Self-checking bench for muldiv_sequencer (vectors + random model)
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V semantics from plain 64-bit / integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    // Issue one request and wait for resp_valid; lat = edges after accept
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 3'($urandom);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        res = resp_result;
        if (lat >= 40) begin
            @(negedge clock);
            flush = 1'b1;
            @(negedge clock);
            flush = 1'b0;
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check({name, "_idle_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        vec_t        vecs[15];
        logic [31:0] res, held;
        int          lat;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        32};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         32};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
        vecs[13] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0,         32};
        vecs[14] = '{3'd3, 32'h8000_0000, 32'd2,         32'd1,         32};

        #12;
        check("reset_req_ready",  {31'd0, req_ready},  32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_busy",       {31'd0, busy},       32'd0);
        check("reset_result",     resp_result,         32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            finish_op($sformatf("vec%0d", i));
        end

        // Stalled response must hold steady
        run_op(3'd5, 32'd1000, 32'd3, held, lat);
        check("stall_result", held, 32'd333);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("stall_hold_result", resp_result, held);
            check("stall_req_ready",   {31'd0, req_ready},  32'd0);
            check("stall_resp_valid",  {31'd0, resp_valid}, 32'd1);
        end
        finish_op("stall");
        run_op(3'd0, 32'd7, 32'd6, res, lat);
        check("after_stall_result", res, 32'd42);
        check("after_stall_latency", lat, 32);
        finish_op("after_stall");

        // Flush mid-divide
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'd13;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy",       {31'd0, busy},       32'd0);
        check("flush_req_ready",  {31'd0, req_ready},  32'd1);
        check("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("flush_keeps_result", resp_result, 32'd42);
        repeat (35) @(posedge clock);
        #1;
        check("flush_no_late_resp", {31'd0, resp_valid}, 32'd0);

        // Flush and request together in IDLE
        @(negedge clock);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_req_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("flush_req_still_idle", {31'd0, busy}, 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          r;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 15);
            if (r < 2)       b = 32'd0;
            else if (r == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r < 5)  b = 32'($urandom_range(1, 255));
            else if (r == 5) a = 32'($urandom_range(0, 1000));
            run_op(op, a, b, res, lat);
            check($sformatf("rand%0d_op%0d_result", i, op), res, ref_model(op, a, b));
            check($sformatf("rand%0d_latency", i), lat, ref_lat(op, a, b));
            finish_op($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-operation
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("areset_req_ready",  {31'd0, req_ready},  32'd1);
        check("areset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("areset_busy",       {31'd0, busy},       32'd0);
        check("areset_result",     resp_result,         32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(3'd5, 32'd100, 32'd7, res, lat);
        check("post_reset_result", res, 32'd14);
        check("post_reset_latency", lat, 32);
        finish_op("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
